hazard_unit_mc: RTL and testbench
=================================

Name: hazard_unit_mc

Overview:
- Parametrised next-generation hazard unit for the 5-stage ARM pipeline (F/D/E/M/W).
- Compares register addresses internally and handles NSRC source operands.
- Adds multi-cycle data-memory stalls with a timeout watchdog, an internal PC-write-pending tracker, and a saturating stall performance counter.
- Sits beside the datapath and drives the stall, flush and forward controls of every pipeline register.

Parameters:
- RA_W, 4, register-address width.
- NSRC, 3, source operands per instruction (Rn, Rm, Rs).
- PC_REG, 15, architectural PC register index; never forwarded.
- TIMEOUT, 64, consecutive memory-wait cycles before MemTimeout is set.
- CNT_W, 16, stall performance counter width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- RAD  in  NSRC*RA_W  D-stage source addresses; slot i = bits [i*RA_W +: RA_W]
- SrcValidD  in  NSRC  D-stage source slot i is read
- RAE  in  NSRC*RA_W  E-stage source addresses
- WA3E, WA3M, WA3W  in  RA_W each  destination address per stage
- RegWriteE, RegWriteM, RegWriteW  in  1 each  stage writes register file
- MemtoRegE  in  1  E-stage instruction is a load
- BranchTakenE  in  1  branch resolved taken in E
- PCWrD  in  1  D-stage instruction may write PC (condition-independent)
- PCWrW  in  1  W-stage instruction may write PC (condition-independent)
- PCSrcW  in  1  W-stage instruction actually writes PC this cycle
- MemReqM  in  1  M-stage data-memory access valid
- MemReadyM  in  1  data memory completes access this cycle
- ForwardE  out  2*NSRC  per-slot select: 00 regfile, 01 ResultW, 10 ALUOutM
- StallF, StallD, StallE, StallM  out  1 each  hold pipeline register
- FlushD, FlushE, FlushW  out  1 each  clear pipeline register
- PCWrPendingF  out  1  PC writer in flight
- StallCount  out  CNT_W  cycles with StallD=1, saturating
- MemTimeout  out  1  sticky watchdog error
- PcPendErr  out  1  sticky tracker overflow/underflow

Behaviour:
- Reset: asynchronous, active-high; clears pc_pend, wait_cnt, StallCount, MemTimeout, PcPendErr. Asserting reset mid-stall releases all stalls in the same cycle.
- Combinational outputs follow inputs in the same cycle. Registered outputs update on the next clk edge.
- MemStall = MemReqM & !MemReadyM.
- LDRstall = MemtoRegE & RegWriteE & OR over i of (SrcValidD[i] & RAD_i == WA3E & RAD_i != PC_REG).
- Forwarding, slot i:
  - RAE_i == PC_REG → 00.
  - Otherwise RAE_i == WA3M & RegWriteM → 10.
  - Otherwise RAE_i == WA3W & RegWriteW → 01.
  - Otherwise 00.
  - M takes priority over W.
- pc_pend, 2-bit counter:
  - Increment when PCWrD & !StallD & !FlushE.
  - Decrement when PCWrW.
  - Both in the same cycle → unchanged.
  - Increment at 3 or decrement at 0 → value held, PcPendErr set (sticky).
- PCWrPendingF = PCWrD | (pc_pend > PCWrW). The writer in W is not counted as pending.
- StallM = StallE = MemStall.
- StallD = MemStall | LDRstall.
- StallF = MemStall | LDRstall | PCWrPendingF.
- FlushW = MemStall (bubble into W; W instruction retires normally).
- FlushD = PCSrcW | (!MemStall & (PCWrPendingF | BranchTakenE)).
- FlushE = !MemStall & (LDRstall | BranchTakenE).
- Simultaneous MemStall and LDRstall: MemStall dominates; LDRstall is re-evaluated after release.
- wait_cnt:
  - Increments on each MemStall cycle, saturating at TIMEOUT.
  - Clears on any cycle with MemStall=0.
  - MemTimeout sets the cycle after wait_cnt reaches TIMEOUT; it stays set until reset.
  - Stalls continue while MemTimeout is set.
- StallCount: +1 per cycle with StallD=1; holds at 2^CNT_W-1.

Test Plan:
- Forwarding priority: RAE slot0=3, WA3M=3, WA3W=3, RegWriteM=RegWriteW=1 → ForwardE[1:0]=10. Drop RegWriteM → 01. Set RAE slot0=15 → 00.
- Load-use: MemtoRegE=1, RegWriteE=1, WA3E=5, RAD slot2=5, SrcValidD=100 → StallF=StallD=FlushE=1 for one cycle. Repeat with SrcValidD=000 → no stall.
- Memory wait: MemReqM=1, MemReadyM=0 for 3 cycles → StallF/D/E/M=1, FlushW=1, FlushE=0 each cycle. MemReadyM=1 on cycle 4 → all stalls drop. StallCount increases by 3.
- Timeout (TIMEOUT=4): MemReadyM held 0 for 6 cycles → MemTimeout=1 from cycle 5 and still 1 after MemReadyM=1. Assert reset mid-stall → MemTimeout=0, stalls release immediately.
- PC tracker: PCWrD=1 accepted → pc_pend=1, PCWrPendingF=1, FlushD=1. Two cycles later PCWrW=1, PCSrcW=1 → PCWrPendingF=0, FlushD=1, pc_pend=0. PCWrW=1 with pc_pend=0 → PcPendErr=1.
- Taken branch during MemStall: BranchTakenE=1, MemStall=1 → FlushD=FlushE=0. MemStall release → FlushD=FlushE=1 that cycle.

Source files
------------

// File: rtl/hazard_unit_mc.sv
// Hazard unit for the 5-stage F/D/E/M/W pipeline: forwarding, stalls,
// flushes, memory-wait watchdog, PC-writer tracking and stall counter.
//
// Ports:
//   clk, reset        clock, async active-high reset
//   RAD/SrcValidD     D-stage source addresses / slot-read flags
//   RAE               E-stage source addresses
//   WA3E/M/W          destination address per stage
//   RegWriteE/M/W     stage writes the register file
//   MemtoRegE         E-stage load
//   BranchTakenE      branch resolved taken in E
//   PCWrD/PCWrW       D/W instruction may write PC
//   PCSrcW            W instruction writes PC this cycle
//   MemReqM/MemReadyM data-memory request / completion
//   ForwardE          per-slot select: 00 regfile, 01 ResultW, 10 ALUOutM
//   StallF/D/E/M      hold pipeline registers
//   FlushD/E/W        clear pipeline registers
//   PCWrPendingF      a PC writer is in flight
//   StallCount        saturating count of StallD cycles
//   MemTimeout        sticky memory-wait watchdog error
//   PcPendErr         sticky PC tracker overflow/underflow
module hazard_unit_mc #(
    parameter int RA_W    = 4,
    parameter int NSRC    = 3,
    parameter int PC_REG  = 15,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NSRC*RA_W-1:0] RAD,
    input  logic [NSRC-1:0]      SrcValidD,
    input  logic [NSRC*RA_W-1:0] RAE,
    input  logic [RA_W-1:0]      WA3E,
    input  logic [RA_W-1:0]      WA3M,
    input  logic [RA_W-1:0]      WA3W,
    input  logic                 RegWriteE,
    input  logic                 RegWriteM,
    input  logic                 RegWriteW,
    input  logic                 MemtoRegE,
    input  logic                 BranchTakenE,
    input  logic                 PCWrD,
    input  logic                 PCWrW,
    input  logic                 PCSrcW,
    input  logic                 MemReqM,
    input  logic                 MemReadyM,
    output logic [2*NSRC-1:0]    ForwardE,
    output logic                 StallF,
    output logic                 StallD,
    output logic                 StallE,
    output logic                 StallM,
    output logic                 FlushD,
    output logic                 FlushE,
    output logic                 FlushW,
    output logic                 PCWrPendingF,
    output logic [CNT_W-1:0]     StallCount,
    output logic                 MemTimeout,
    output logic                 PcPendErr
);

    localparam int WC_W = $clog2(TIMEOUT + 1);
    localparam logic [RA_W-1:0] PC_A = RA_W'(PC_REG);
    localparam logic [WC_W-1:0] WC_MAX = WC_W'(TIMEOUT);

    logic            mem_stall;
    logic            ldr_hit;
    logic            ldr_stall;
    logic [1:0]      pc_pend;
    logic            pc_inc;
    logic            pc_dec;
    logic [WC_W-1:0] wait_cnt;
    logic [WC_W-1:0] wait_nxt;

    // Stalls are gated by reset so an in-progress stall releases at once.
    assign mem_stall = MemReqM & ~MemReadyM & ~reset;

    always_comb begin
        ldr_hit = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (SrcValidD[i] &&
                RAD[i*RA_W +: RA_W] == WA3E &&
                RAD[i*RA_W +: RA_W] != PC_A)
                ldr_hit = 1'b1;
        end
    end

    assign ldr_stall = MemtoRegE & RegWriteE & ldr_hit & ~reset;

    // M-stage result is younger than W, so it wins.
    always_comb begin
        ForwardE = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (RAE[i*RA_W +: RA_W] == PC_A)
                ForwardE[2*i +: 2] = 2'b00;
            else if (RAE[i*RA_W +: RA_W] == WA3M && RegWriteM)
                ForwardE[2*i +: 2] = 2'b10;
            else if (RAE[i*RA_W +: RA_W] == WA3W && RegWriteW)
                ForwardE[2*i +: 2] = 2'b01;
        end
    end

    // The writer already in W is not counted as pending.
    assign PCWrPendingF = ~reset &
        (PCWrD | (pc_pend > {1'b0, PCWrW}));

    assign StallM = mem_stall;
    assign StallE = mem_stall;
    assign StallD = mem_stall | ldr_stall;
    assign StallF = mem_stall | ldr_stall | PCWrPendingF;
    assign FlushW = mem_stall;
    assign FlushD = PCSrcW |
        (~mem_stall & (PCWrPendingF | BranchTakenE));
    assign FlushE = ~mem_stall & (ldr_stall | BranchTakenE);

    assign pc_inc = PCWrD & ~StallD & ~FlushE;
    assign pc_dec = PCWrW;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_pend   <= 2'd0;
            PcPendErr <= 1'b0;
        end else if (pc_inc && !pc_dec) begin
            if (pc_pend == 2'd3)
                PcPendErr <= 1'b1;
            else
                pc_pend <= pc_pend + 2'd1;
        end else if (pc_dec && !pc_inc) begin
            if (pc_pend == 2'd0)
                PcPendErr <= 1'b1;
            else
                pc_pend <= pc_pend - 2'd1;
        end
    end

    always_comb begin
        wait_nxt = '0;
        if (mem_stall)
            wait_nxt = (wait_cnt == WC_MAX) ? wait_cnt
                                            : wait_cnt + 1'b1;
    end

    // Timeout is flagged on the same edge wait_cnt reaches the limit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt   <= '0;
            MemTimeout <= 1'b0;
        end else begin
            wait_cnt <= wait_nxt;
            if (wait_nxt == WC_MAX)
                MemTimeout <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            StallCount <= '0;
        else if (StallD && StallCount != '1)
            StallCount <= StallCount + 1'b1;
    end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed self-checking bench for hazard_unit_mc
// (TIMEOUT=4, CNT_W=4 to reach the watchdog and counter limits).
module tb_hazard_unit_mc;

    localparam int RA_W  = 4;
    localparam int NSRC  = 3;
    localparam int CNT_W = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NSRC*RA_W-1:0] RAD;
    logic [NSRC-1:0]      SrcValidD;
    logic [NSRC*RA_W-1:0] RAE;
    logic [RA_W-1:0]      WA3E, WA3M, WA3W;
    logic                 RegWriteE, RegWriteM, RegWriteW;
    logic                 MemtoRegE, BranchTakenE;
    logic                 PCWrD, PCWrW, PCSrcW;
    logic                 MemReqM, MemReadyM;
    logic [2*NSRC-1:0]    ForwardE;
    logic                 StallF, StallD, StallE, StallM;
    logic                 FlushD, FlushE, FlushW;
    logic                 PCWrPendingF;
    logic [CNT_W-1:0]     StallCount;
    logic                 MemTimeout, PcPendErr;

    int checks = 0;
    int errors = 0;

    hazard_unit_mc #(
        .RA_W(RA_W), .NSRC(NSRC), .PC_REG(15),
        .TIMEOUT(4), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .RAD(RAD), .SrcValidD(SrcValidD), .RAE(RAE),
        .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
        .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
        .BranchTakenE(BranchTakenE), .PCWrD(PCWrD),
        .PCWrW(PCWrW), .PCSrcW(PCSrcW),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .ForwardE(ForwardE),
        .StallF(StallF), .StallD(StallD),
        .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .PCWrPendingF(PCWrPendingF), .StallCount(StallCount),
        .MemTimeout(MemTimeout), .PcPendErr(PcPendErr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        RAD = '0; SrcValidD = '0; RAE = '0;
        WA3E = '0; WA3M = '0; WA3W = '0;
        RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
        MemtoRegE = 0; BranchTakenE = 0;
        PCWrD = 0; PCWrW = 0; PCSrcW = 0;
        MemReqM = 0; MemReadyM = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit");
        $fatal(1, "timeout");
    end

    initial begin
        clr();
        reset = 1'b1;
        #1;
        chk("rst_cnt", 32'(StallCount), 0);
        chk("rst_tmo", 32'(MemTimeout), 0);
        chk("rst_err", 32'(PcPendErr), 0);
        chk("rst_pend", 32'(PCWrPendingF), 0);
        chk("rst_stallf", 32'(StallF), 0);
        tick();
        reset = 1'b0;
        #1;

        // Forwarding priority
        RAE = 12'h003; WA3M = 3; WA3W = 3;
        RegWriteM = 1; RegWriteW = 1;
        #1 chk("fwd_m", 32'(ForwardE), 32'h02);
        RegWriteM = 0;
        #1 chk("fwd_w", 32'(ForwardE), 32'h01);
        RAE = 12'h00F; WA3M = 15; WA3W = 15; RegWriteM = 1;
        #1 chk("fwd_pc", 32'(ForwardE), 32'h00);
        RAE = 12'h30F; RegWriteM = 0; WA3W = 3;
        #1 chk("fwd_slot2", 32'(ForwardE), 32'h10);
        clr();

        // Load-use
        MemtoRegE = 1; RegWriteE = 1; WA3E = 5;
        RAD = 12'h500; SrcValidD = 3'b100;
        #1;
        chk("ldr_stallf", 32'(StallF), 1);
        chk("ldr_stalld", 32'(StallD), 1);
        chk("ldr_flushe", 32'(FlushE), 1);
        chk("ldr_stalle", 32'(StallE), 0);
        tick();
        chk("ldr_cnt", 32'(StallCount), 1);
        SrcValidD = 3'b000;
        #1 chk("ldr_novalid", 32'(StallD), 0);
        WA3E = 15; RAD = 12'hF00; SrcValidD = 3'b100;
        #1 chk("ldr_pcreg", 32'(StallD), 0);
        clr();

        // Memory wait, three cycles
        MemReqM = 1; MemReadyM = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("mw_stall", 32'({StallF, StallD, StallE, StallM}),
                32'hF);
            chk("mw_flushw", 32'(FlushW), 1);
            chk("mw_flushe", 32'(FlushE), 0);
            tick();
        end
        MemReadyM = 1;
        #1;
        chk("mw_release", 32'({StallF, StallD, StallE, StallM}), 0);
        chk("mw_flushw0", 32'(FlushW), 0);
        chk("mw_cnt", 32'(StallCount), 4);
        tick();
        clr();
        #1 chk("mw_notmo", 32'(MemTimeout), 0);

        // Timeout
        MemReqM = 1; MemReadyM = 0;
        for (int k = 1; k <= 6; k++) begin
            #1;
            chk("tmo_cyc", 32'(MemTimeout), (k >= 5) ? 1 : 0);
            chk("tmo_stall", 32'(StallD), 1);
            tick();
        end
        MemReadyM = 1;
        #1 chk("tmo_sticky", 32'(MemTimeout), 1);
        tick();
        MemReadyM = 0;
        #1 chk("tmo_stall_again", 32'(StallM), 1);
        reset = 1'b1;
        #1;
        chk("tmo_rst", 32'(MemTimeout), 0);
        chk("tmo_rst_stall",
            32'({StallF, StallD, StallE, StallM}), 0);
        chk("tmo_rst_cnt", 32'(StallCount), 0);
        tick();
        reset = 1'b0;
        clr();
        #1;

        // PC tracker
        PCWrD = 1;
        #1;
        chk("pc_pendd", 32'(PCWrPendingF), 1);
        chk("pc_flushd", 32'(FlushD), 1);
        chk("pc_stallf", 32'(StallF), 1);
        tick();
        PCWrD = 0;
        #1 chk("pc_pend1", 32'(PCWrPendingF), 1);
        chk("pc_flushd1", 32'(FlushD), 1);
        tick();
        tick();
        PCWrW = 1; PCSrcW = 1;
        #1;
        chk("pc_w_pend", 32'(PCWrPendingF), 0);
        chk("pc_w_flushd", 32'(FlushD), 1);
        tick();
        PCWrW = 0; PCSrcW = 0;
        #1;
        chk("pc_drained", 32'(PCWrPendingF), 0);
        chk("pc_noerr", 32'(PcPendErr), 0);
        // writer blocked by a load-use stall is not counted
        MemtoRegE = 1; RegWriteE = 1; WA3E = 5;
        RAD = 12'h005; SrcValidD = 3'b001; PCWrD = 1;
        tick();
        clr();
        #1 chk("pc_blocked", 32'(PCWrPendingF), 0);
        PCWrW = 1;
        #1 chk("pc_under_pre", 32'(PcPendErr), 0);
        tick();
        PCWrW = 0;
        #1 chk("pc_under", 32'(PcPendErr), 1);
        clr();

        // Taken branch under memory stall
        BranchTakenE = 1; MemReqM = 1; MemReadyM = 0;
        #1;
        chk("br_ms_flushd", 32'(FlushD), 0);
        chk("br_ms_flushe", 32'(FlushE), 0);
        tick();
        MemReadyM = 1;
        #1;
        chk("br_rel_flushd", 32'(FlushD), 1);
        chk("br_rel_flushe", 32'(FlushE), 1);
        tick();
        clr();

        // Stall counter saturation (4-bit)
        do_reset();
        MemtoRegE = 1; RegWriteE = 1; WA3E = 7;
        RAD = 12'h070; SrcValidD = 3'b010;
        for (int k = 0; k < 14; k++) tick();
        chk("cnt_14", 32'(StallCount), 14);
        for (int k = 0; k < 6; k++) tick();
        chk("cnt_sat", 32'(StallCount), 15);
        clr();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
